ex_alu_fwd_unit: RTL and testbench

- Execute-stage arithmetic block of the 5-stage MIPS pipeline.
- Combines three functions:
  - ALU-control decode: ALUop plus funct gives a 4-bit operation code.
  - 32-bit ALU with an 8-bit status vector.
  - ID-stage forwarding selector for the early branch compare.
- Also provides a registered copy of result and status for the EX/MEM boundary.
- Sits between the ID/EX register and the EX/MEM register.

---
 rtl/ex_alu_fwd_unit.sv | 158 +++++++++++++++
 tb/tb_ex_alu_fwd_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ex_alu_fwd_unit.sv
// Execute-stage arithmetic block: ALU-control decode, 32-bit ALU with status,
// a registered copy of result/status, and the ID-stage branch forwarding select.
module ex_alu_fwd_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] source_data1,
  input  logic [WIDTH-1:0] source_data2,
  output logic [3:0]       ALU_control_signal,
  output logic [WIDTH-1:0] ALU_result,
  output logic [7:0]       ALU_status,
  output logic [WIDTH-1:0] ALU_result_q,
  output logic [7:0]       ALU_status_q,
  input  logic             ID_EX_RegWrite,
  input  logic             EX_MEM_RegWrite,
  input  logic [4:0]       ID_EX_rd,
  input  logic [4:0]       EX_MEM_rd,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  output logic [1:0]       F1,
  output logic [1:0]       F2
);

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_XOR     = 4'b0011;
  localparam logic [3:0] OP_NOR     = 4'b0100;
  localparam logic [3:0] OP_SLL     = 4'b0101;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_SRL     = 4'b1000;
  localparam logic [3:0] OP_SRA     = 4'b1001;
  localparam logic [3:0] OP_ADDU    = 4'b1010;
  localparam logic [3:0] OP_SUBU    = 4'b1011;
  localparam logic [3:0] OP_SLTU    = 4'b1100;
  localparam logic [3:0] OP_INVALID = 4'b1111;

  logic [3:0]       op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             lt_signed;
  logic [WIDTH-1:0] result;
  logic [7:0]       status;

  always_comb begin
    op = OP_INVALID;
    unique case (ALUop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_SLT;
      default: begin
        case (funct)
          6'h20: op = OP_ADD;
          6'h21: op = OP_ADDU;
          6'h22: op = OP_SUB;
          6'h23: op = OP_SUBU;
          6'h24: op = OP_AND;
          6'h25: op = OP_OR;
          6'h26: op = OP_XOR;
          6'h27: op = OP_NOR;
          6'h2A: op = OP_SLT;
          6'h2B: op = OP_SLTU;
          6'h00: op = OP_SLL;
          6'h02: op = OP_SRL;
          6'h03: op = OP_SRA;
          default: op = OP_INVALID;
        endcase
      end
    endcase
  end

  assign sum_ext   = {1'b0, source_data1} + {1'b0, source_data2};
  assign diff      = source_data1 - source_data2;
  assign borrow    = source_data1 < source_data2;
  assign lt_signed = $signed(source_data1) < $signed(source_data2);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDU: result = sum_ext[WIDTH-1:0];
      OP_SUB, OP_SUBU: result = diff;
      OP_AND:          result = source_data1 & source_data2;
      OP_OR:           result = source_data1 | source_data2;
      OP_XOR:          result = source_data1 ^ source_data2;
      OP_NOR:          result = ~(source_data1 | source_data2);
      OP_SLT:          result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU:         result = {{(WIDTH-1){1'b0}}, borrow};
      OP_SLL:          result = source_data2 << shamt;
      OP_SRL:          result = source_data2 >> shamt;
      OP_SRA:          result = $unsigned($signed(source_data2) >>> shamt);
      default:         result = '0;
    endcase
  end

  // Overflow only for the trapping forms; carry doubles as borrow on subtraction.
  always_comb begin
    status    = 8'h00;
    status[0] = (result == '0);
    case (op)
      OP_ADD: begin
        status[1] = (source_data1[WIDTH-1] == source_data2[WIDTH-1]) &&
                    (result[WIDTH-1] != source_data1[WIDTH-1]);
        status[2] = sum_ext[WIDTH];
      end
      OP_ADDU: status[2] = sum_ext[WIDTH];
      OP_SUB: begin
        status[1] = (source_data1[WIDTH-1] != source_data2[WIDTH-1]) &&
                    (result[WIDTH-1] != source_data1[WIDTH-1]);
        status[2] = borrow;
      end
      OP_SUBU: status[2] = borrow;
      default: ;
    endcase
    status[3] = result[WIDTH-1];
    status[4] = (op == OP_INVALID);
    status[5] = (result[1:0] != 2'b00);
  end

  assign ALU_control_signal = op;
  assign ALU_result         = result;
  assign ALU_status         = status;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ALU_result_q <= '0;
      ALU_status_q <= 8'h00;
    end else begin
      ALU_result_q <= result;
      ALU_status_q <= status;
    end
  end

  // EX match wins over MEM match; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       ex_we,
    input logic [4:0] ex_rd,
    input logic       mem_we,
    input logic [4:0] mem_rd
  );
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == src))
      return 2'b01;
    else if (mem_we && (mem_rd != 5'd0) && (mem_rd == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign F1 = fwd_sel(IF_ID_rs, ID_EX_RegWrite, ID_EX_rd, EX_MEM_RegWrite, EX_MEM_rd);
  assign F2 = fwd_sel(IF_ID_rt, ID_EX_RegWrite, ID_EX_rd, EX_MEM_RegWrite, EX_MEM_rd);

endmodule

// File: tb/tb_ex_alu_fwd_unit.sv
// Directed-vector bench for ex_alu_fwd_unit with hand-computed expectations.
module tb_ex_alu_fwd_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ALUop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] source_data1;
  logic [31:0] source_data2;
  logic [3:0]  ALU_control_signal;
  logic [31:0] ALU_result;
  logic [7:0]  ALU_status;
  logic [31:0] ALU_result_q;
  logic [7:0]  ALU_status_q;
  logic        ID_EX_RegWrite;
  logic        EX_MEM_RegWrite;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  EX_MEM_rd;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic [1:0]  F1;
  logic [1:0]  F2;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  ex_alu_fwd_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .ALUop(ALUop),
    .funct(funct),
    .shamt(shamt),
    .source_data1(source_data1),
    .source_data2(source_data2),
    .ALU_control_signal(ALU_control_signal),
    .ALU_result(ALU_result),
    .ALU_status(ALU_status),
    .ALU_result_q(ALU_result_q),
    .ALU_status_q(ALU_status_q),
    .ID_EX_RegWrite(ID_EX_RegWrite),
    .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .ID_EX_rd(ID_EX_rd),
    .EX_MEM_rd(EX_MEM_rd),
    .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt),
    .F1(F1),
    .F2(F2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Apply an ALU vector between edges and check ctrl/result/status once settled.
  task automatic alu_vec(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_ctrl, input logic [31:0] exp_res,
                         input logic [7:0] exp_stat);
    @(negedge clk);
    ALUop = op; funct = fn; shamt = sh; source_data1 = a; source_data2 = b;
    #1;
    check({tag, ".ctrl"}, {28'd0, ALU_control_signal}, {28'd0, exp_ctrl});
    check({tag, ".res"},  ALU_result, exp_res);
    check({tag, ".stat"}, {24'd0, ALU_status}, {24'd0, exp_stat});
  endtask

  task automatic fwd_vec(input string tag, input logic ex_we, input logic mem_we,
                         input logic [4:0] ex_rd, input logic [4:0] mem_rd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] exp_f1, input logic [1:0] exp_f2);
    ID_EX_RegWrite = ex_we; EX_MEM_RegWrite = mem_we;
    ID_EX_rd = ex_rd; EX_MEM_rd = mem_rd; IF_ID_rs = rs; IF_ID_rt = rt;
    #1;
    check({tag, ".F1"}, {30'd0, F1}, {30'd0, exp_f1});
    check({tag, ".F2"}, {30'd0, F2}, {30'd0, exp_f2});
  endtask

  initial begin
    reset = 1'b0;
    ALUop = 2'b00; funct = 6'h00; shamt = 5'd0;
    source_data1 = 32'd0; source_data2 = 32'd0;
    ID_EX_RegWrite = 1'b0; EX_MEM_RegWrite = 1'b0;
    ID_EX_rd = 5'd0; EX_MEM_rd = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;

    // Registered path held in reset for two edges
    source_data1 = 32'h0000_0003; source_data2 = 32'h0000_0004;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.res_q",  ALU_result_q, 32'h0);
    check("rst.stat_q", {24'd0, ALU_status_q}, 32'h0);

    // Release reset with result 0x12345678 (ADD 0x12345670 + 8)
    ALUop = 2'b00; source_data1 = 32'h1234_5670; source_data2 = 32'h0000_0008;
    reset = 1'b1;
    #1;
    check("pre.res_q", ALU_result_q, 32'h0);
    @(posedge clk); @(negedge clk);
    check("run.res_q",  ALU_result_q, 32'h1234_5678);
    check("run.stat_q", {24'd0, ALU_status_q}, 32'h0);

    // Next vector flows through, then reset reasserted mid-stream
    source_data1 = 32'h0000_0001; source_data2 = 32'h0000_0001;
    @(posedge clk); @(negedge clk);
    check("run2.res_q", ALU_result_q, 32'h2);
    check("run2.stat_q", {24'd0, ALU_status_q}, 32'h20);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst2.res_q",  ALU_result_q, 32'h0);
    check("rst2.stat_q", {24'd0, ALU_status_q}, 32'h0);
    reset = 1'b1;

    // ALU / decode vectors
    alu_vec("add_ovf",  2'b10, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1,          4'b0010, 32'h8000_0000, 8'h0A);
    alu_vec("beq_eq",   2'b01, 6'h00, 5'd0, 32'd5,         32'd5,          4'b0110, 32'h0,         8'h01);
    alu_vec("beq_lt",   2'b01, 6'h00, 5'd0, 32'd3,         32'd5,          4'b0110, 32'hFFFF_FFFE, 8'h2C);
    alu_vec("sra",      2'b10, 6'h03, 5'd4, 32'h0,         32'hF000_0000,  4'b1001, 32'hFF00_0000, 8'h08);
    alu_vec("srl",      2'b10, 6'h02, 5'd4, 32'h0,         32'hF000_0000,  4'b1000, 32'h0F00_0000, 8'h00);
    alu_vec("sltu",     2'b10, 6'h2B, 5'd0, 32'h1,         32'hFFFF_FFFF,  4'b1100, 32'h1,         8'h20);
    alu_vec("slt",      2'b10, 6'h2A, 5'd0, 32'h1,         32'hFFFF_FFFF,  4'b0111, 32'h0,         8'h01);
    alu_vec("invalid",  2'b10, 6'h3F, 5'd0, 32'h1234,      32'h5678,       4'b1111, 32'h0,         8'h11);
    alu_vec("addu_cy",  2'b10, 6'h21, 5'd0, 32'hFFFF_FFFF, 32'h1,          4'b1010, 32'h0,         8'h05);
    alu_vec("sub_ovf",  2'b10, 6'h22, 5'd0, 32'h8000_0000, 32'h1,          4'b0110, 32'h7FFF_FFFF, 8'h22);
    alu_vec("subu",     2'b10, 6'h23, 5'd0, 32'h8000_0000, 32'h1,          4'b1011, 32'h7FFF_FFFF, 8'h20);
    alu_vec("and",      2'b10, 6'h24, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,  4'b0000, 32'hF000_F000, 8'h08);
    alu_vec("or",       2'b10, 6'h25, 5'd0, 32'h0F0F_0000, 32'h0000_00F4,  4'b0001, 32'h0F0F_00F4, 8'h00);
    alu_vec("xor",      2'b10, 6'h26, 5'd0, 32'hFFFF_0000, 32'hFF00_FF00,  4'b0011, 32'h00FF_FF00, 8'h00);
    alu_vec("nor",      2'b10, 6'h27, 5'd0, 32'hFFFF_0000, 32'h0000_FFF0,  4'b0100, 32'h0000_000F, 8'h20);
    alu_vec("sll",      2'b10, 6'h00, 5'd31, 32'h0,        32'h0000_0003,  4'b0101, 32'h8000_0000, 8'h08);
    alu_vec("slti",     2'b11, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h1,          4'b0111, 32'h1,         8'h20);

    // Forwarding vectors
    fwd_vec("fwd_ex",   1'b1, 1'b1, 5'd8, 5'd8, 5'd8, 5'd8, 2'b01, 2'b01);
    fwd_vec("fwd_mem",  1'b0, 1'b1, 5'd8, 5'd8, 5'd8, 5'd8, 2'b10, 2'b10);
    fwd_vec("fwd_r0",   1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00);
    fwd_vec("fwd_rs9",  1'b1, 1'b1, 5'd8, 5'd9, 5'd9, 5'd7, 2'b10, 2'b00);
    fwd_vec("fwd_rt",   1'b1, 1'b1, 5'd7, 5'd9, 5'd3, 5'd7, 2'b00, 2'b01);
    fwd_vec("fwd_nowe", 1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 5'd8, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
